clk_div_multi: RTL

Parametrised multi-channel clock divider and the successor to the fixed 1 Hz divider. It is clocked from the 50 MHz board clock.
- Each channel produces a registered 50%-duty divided clock plus a one-cycle tick strobe.
- Each channel's half-period can be reloaded at runtime through a valid/ready config port.
- Reloads apply only at period boundaries, so no runt pulses occur.
- Feeds display refresh, debounce sampling and seconds counters.

---
 rtl/clk_div_pkg.sv | 11 +
 rtl/clk_div_multi_if.sv | 17 +
 rtl/clk_div_ch.sv | 74 +++++++
 rtl/clk_div_multi.sv | 52 +++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel clock divider.
package clk_div_pkg;
  localparam int CLK50_HZ  = 50_000_000;
  localparam int DEF_DIV_W = 26;
  localparam int HALF_1HZ  = 25_000_000;
  localparam int HALF_1KHZ = 25_000;

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction
endpackage

// File: rtl/clk_div_multi_if.sv
// Config handshake bundle: one valid/ready transfer queues a new half-period for one channel.
interface clk_div_multi_if
  import clk_div_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W  = DEF_DIV_W
) ();
  localparam int CH_W = ch_idx_w(NUM_CH);

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_half;

  modport master (output cfg_valid, output cfg_ch, output cfg_half, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_half, output cfg_ready);
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: counter, half-period, pending reload and registered clk_out/tick.
// CLKDIV_TICK_COUNT_EN adds a 16-bit wrapping tick counter output.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int DIV_W        = DEF_DIV_W,
  parameter int DEFAULT_HALF = HALF_1HZ
) (
  input  logic             clk50,
  input  logic             reset_n,
  input  logic             en,
  input  logic             ld_req,
  input  logic [DIV_W-1:0] ld_half,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
`ifdef CLKDIV_TICK_COUNT_EN
  ,
  output logic [15:0]      tick_cnt
`endif
);
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] half;
  logic [DIV_W-1:0] pend_val;
  logic             active;
  logic             wrap;
  logic             apply;

  assign active = en && (half != '0);
  assign wrap   = active && (cnt == half - DIV_W'(1));
  // A reload lands only where a low phase starts anyway, so no runt pulse.
  assign apply  = pending && (!active || (wrap && clk_out));

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      half     <= DIV_W'(DEFAULT_HALF);
      pend_val <= '0;
      pending  <= 1'b0;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      tick <= wrap && !clk_out;
      if (!active) begin
        cnt     <= '0;
        clk_out <= 1'b0;
      end else if (wrap) begin
        cnt     <= '0;
        clk_out <= !clk_out;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
      if (apply) begin
        half    <= pend_val;
        pending <= 1'b0;
      end else if (ld_req && !pending) begin
        pend_val <= ld_half;
        pending  <= 1'b1;
      end
    end
  end

`ifdef CLKDIV_TICK_COUNT_EN
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt <= '0;
    end else if (apply) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel 50%-duty clock divider with runtime half-period reload per channel.
// CLKDIV_TICK_COUNT_EN adds the per-channel tick_cnt output.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH       = 2,
  parameter int DIV_W        = DEF_DIV_W,
  parameter int DEFAULT_HALF = HALF_1HZ
) (
  input  logic              clk50,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] en,
  clk_div_multi_if.slave    cfg,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
`ifdef CLKDIV_TICK_COUNT_EN
  ,
  output logic [NUM_CH*16-1:0] tick_cnt
`endif
);
  localparam int CH_W = ch_idx_w(NUM_CH);

  logic [NUM_CH-1:0] pending;

  // Out-of-range channel numbers match nothing: ready stays high and nothing loads.
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) cfg.cfg_ready = !pending[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_ch #(
      .DIV_W        (DIV_W),
      .DEFAULT_HALF (DEFAULT_HALF)
    ) u_ch (
      .clk50    (clk50),
      .reset_n  (reset_n),
      .en       (en[g]),
      .ld_req   (cfg.cfg_valid && (cfg.cfg_ch == CH_W'(g))),
      .ld_half  (cfg.cfg_half),
      .pending  (pending[g]),
      .clk_out  (clk_out[g]),
      .tick     (tick[g])
`ifdef CLKDIV_TICK_COUNT_EN
      ,
      .tick_cnt (tick_cnt[g*16 +: 16])
`endif
    );
  end
endmodule
